uart_rx_byte: RTL
=================

// Module: uart_rx_byte
// PURPOSE
//  8N1 UART receiver, the receive-side counterpart of the summing system's UART
//  transmitter. Recovers bytes from the serial line, e.g. from a host or a loopback
//  of uart_txd. Presents each byte through a ready/ack holding register with
//  framing-error and overrun flags, for the operand-load logic or a test harness.
// PARAMETERS
//  CLKS_PER_BIT  5208  clk cycles per bit (50 MHz / 9600 baud); integer >= 4
// PORTS
//  clk        in   1  system clock; all logic on its rising edge
//  reset_n    in   1  asynchronous active-low reset
//  uart_rxd   in   1  serial input; idle high; asynchronous to clk
//  rx_ack     in   1  consumer pulse/level; clears rx_ready and overrun_err
//  rx_data    out  8  last good byte received; LSB is the first bit on the line
//  rx_ready   out  1  high while rx_data holds an unacknowledged byte
//  frame_err  out  1  1-cycle pulse: stop bit sampled low
//  overrun_err out 1  sticky: byte completed while rx_ready high; cleared by rx_ack
//  rx_busy    out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset (async assert, sync deassert expected from system):
//   - Outputs: rx_data=8'h00, rx_ready=0, frame_err=0, overrun_err=0, rx_busy=0.
//   - Internal: FSM=IDLE, synchroniser flops=1 (idle line), counters=0.
//   - Reset mid-frame abandons the frame. No partial byte is ever presented.
//  Input path:
//   - uart_rxd passes through a 2-flop synchroniser (rxd_s).
//   - All decisions use rxd_s, so there are 2 cycles of input latency.
//  Bit timer: counts 0..CLKS_PER_BIT-1. bit_idx counts 0..7.
//  FSM:
//   - IDLE: rxd_s==0 -> START, timer=0.
//   - START: at timer==CLKS_PER_BIT/2-1 (mid start bit), sample rxd_s.
//     - 0 -> DATA, timer=0, bit_idx=0.
//     - 1 -> glitch, back to IDLE with no flags.
//   - DATA: at timer==CLKS_PER_BIT-1, shift rxd_s into shift reg MSB (right shift,
//     LSB first). bit_idx==7 -> STOP, else bit_idx++. Timer wraps to 0.
//   - STOP: at timer==CLKS_PER_BIT-1, sample rxd_s.
//     - 1 -> DONE.
//     - 0 -> pulse frame_err 1 cycle, go to BREAK; byte discarded.
//   - DONE (1 cycle):
//     - if !rx_ready (after this cycle's ack): rx_data<=shift, rx_ready<=1.
//     - else: byte discarded, overrun_err<=1, rx_data unchanged.
//     - Then IDLE.
//   - BREAK: wait for rxd_s==1, then IDLE. A line held low never retriggers START.
//  Handshake and timing:
//   - rx_ready rises the cycle after DONE, about 9.5 bit times + 3 clk after the
//     line falling edge.
//   - rx_ack with rx_ready==1 clears rx_ready and overrun_err next cycle.
//   - rx_ack with rx_ready==0 clears overrun_err only.
//   - rx_ack and DONE in the same cycle: ack is applied first, so the new byte loads
//     and rx_ready stays 1; no overrun.
//   - rx_data stays stable while rx_ready==1.
//  Sampling tolerance: mid-bit sampling tolerates about +/-4% baud mismatch. There
//   is no oversampled majority vote.
// TESTING (bench uses CLKS_PER_BIT=8)
//  1 Reset, send 0xA5 8N1 -> rx_ready rises, rx_data=0xA5, frame_err never 1;
//    rx_ack -> rx_ready=0.
//  2 Pulse uart_rxd low for 3 clk in IDLE -> returns to IDLE, rx_busy drops,
//    rx_ready=0; then 0x3C is received correctly.
//  3 Send 0x55 with stop bit low, hold the line low 20 bit times, then idle ->
//    one frame_err pulse, no rx_ready, stays in BREAK; next 0x0F received OK.
//  4 Send 0x11 without ack, then 0x22 -> rx_data=0x11, overrun_err=1; rx_ack clears
//    both; next 0x33 received.
//  5 Assert rx_ack in the DONE cycle of 0x77 while holding 0x66 -> rx_data=0x77,
//    rx_ready=1, overrun_err=0.
//  6 Assert reset_n=0 mid DATA of 0xFF, release, send 0x81 -> only 0x81 presented;
//    all outputs are 0 during reset.

Source files
------------

// File: rtl/uart_rx_byte_if.sv
// Receive-side handshake bundle: a byte holding register with ready/ack and status flags.
// The receiver takes the master modport; the consumer takes the slave modport.
interface uart_rx_byte_if;
   logic [7:0] rx_data;
   logic       rx_ready;
   logic       rx_ack;
   logic       frame_err;
   logic       overrun_err;
   logic       rx_busy;

   modport master (
      output rx_data,
      output rx_ready,
      output frame_err,
      output overrun_err,
      output rx_busy,
      input  rx_ack
   );

   modport slave (
      input  rx_data,
      input  rx_ready,
      input  frame_err,
      input  overrun_err,
      input  rx_busy,
      output rx_ack
   );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver with mid-bit sampling.
// Each completed byte is held in a ready/ack register, with framing-error and overrun flags.
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic           clk,
   input  logic           reset_n,
   input  logic           uart_rxd,
   uart_rx_byte_if.master rx
);

   localparam int TW = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] MID  = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      DONE,
      BREAK_WAIT
   } state_t;

   state_t        state;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shift_reg;
   logic          rxd_meta;
   logic          rxd_s;

   // The synchroniser resets to the idle-line level, so reset release cannot look like a start bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rxd_meta <= 1'b1;
         rxd_s    <= 1'b1;
      end else begin
         rxd_meta <= uart_rxd;
         rxd_s    <= rxd_meta;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         timer          <= '0;
         bit_idx        <= '0;
         shift_reg      <= '0;
         rx.rx_data     <= '0;
         rx.rx_ready    <= 1'b0;
         rx.frame_err   <= 1'b0;
         rx.overrun_err <= 1'b0;
         rx.rx_busy     <= 1'b0;
      end else begin
         rx.frame_err <= 1'b0;
         if (rx.rx_ack) begin
            rx.rx_ready    <= 1'b0;
            rx.overrun_err <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (!rxd_s) begin
                  state      <= START;
                  timer      <= '0;
                  rx.rx_busy <= 1'b1;
               end
            end

            // A start bit that is high again at its midpoint was a glitch, not a frame.
            START: begin
               if (timer == MID) begin
                  if (!rxd_s) begin
                     state   <= DATA;
                     timer   <= '0;
                     bit_idx <= '0;
                  end else begin
                     state      <= IDLE;
                     rx.rx_busy <= 1'b0;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            DATA: begin
               if (timer == LAST) begin
                  timer     <= '0;
                  shift_reg <= {rxd_s, shift_reg[7:1]};
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            STOP: begin
               if (timer == LAST) begin
                  timer <= '0;
                  if (rxd_s) begin
                     state <= DONE;
                  end else begin
                     state        <= BREAK_WAIT;
                     rx.frame_err <= 1'b1;
                  end
               end else begin
                  timer <= timer + 1'b1;
               end
            end

            // An ack arriving in this same cycle frees the register before the new byte lands.
            DONE: begin
               state      <= IDLE;
               rx.rx_busy <= 1'b0;
               if (!rx.rx_ready || rx.rx_ack) begin
                  rx.rx_data  <= shift_reg;
                  rx.rx_ready <= 1'b1;
               end else begin
                  rx.overrun_err <= 1'b1;
               end
            end

            BREAK_WAIT: begin
               if (rxd_s) begin
                  state      <= IDLE;
                  rx.rx_busy <= 1'b0;
               end
            end

            default: begin
               state      <= IDLE;
               rx.rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
